i2s_rx: RTL and testbench
=========================

// Module: i2s_rx
// PURPOSE
//  I2S receiver (slave): deserialises an external sclk/lrclk/sdata stream into signed
//  16-bit left/right sample pairs in the clk domain. It is the receive end of the
//  I2S link driven by the core's i2s transmitter and feeds codec-input/loopback
//  audio into the mixer path. All I2S inputs are oversampled; clk >= 4x sclk.
// PARAMETERS
//  DATA_W    16  output word width; bits beyond DATA_W per slot are dropped, LSB-padded if short
//  MIN_BITS   8  shortest legal slot in bits; shorter slot = framing error
// PORTS
//  clk          in   1       system clock, all logic rising-edge
//  reset_n      in   1       asynchronous, active-low reset
//  sclk         in   1       I2S bit clock, async to clk
//  lrclk        in   1       I2S word select, 0 = left, 1 = right, async
//  sdata        in   1       I2S serial data, MSB first, 1-bit delay after lrclk edge
//  left_chan    out  DATA_W  last complete left sample (two's complement)
//  right_chan   out  DATA_W  last complete right sample
//  sample_valid out  1       1-clk pulse: left_chan/right_chan updated together
//  frame_err    out  1       1-clk pulse: short slot detected, pair discarded
//  locked       out  1       high after first good L+R pair, low in SYNC
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low. Assertion clears all
//   state immediately; release is synchronous. Reset values: left_chan=0, right_chan=0,
//   sample_valid=0, frame_err=0, locked=0, FSM=SYNC.
//  Input path: sclk, lrclk, sdata each 2-flop synchronised; sclk rise = sync'd 1 && prev 0.
//   All bit processing happens only on a detected sclk rise ("bit tick"), 3 clk after pin edge.
//  Per bit tick k: sample ws_k, sd_k.
//   - ws_k == ws_{k-1}: shift sd_k into slot shreg if cnt < DATA_W; cnt++ (saturate at 63).
//   - ws_k != ws_{k-1}: sd_k is the LAST bit of the ws_{k-1} slot; append it, then CLOSE
//     that slot; clear shreg/cnt; next tick is MSB of new slot.
//  Close: word = shreg left-aligned (cnt >= DATA_W: first DATA_W bits; else shifted left
//   by DATA_W-cnt, zero LSBs). cnt counts all bits incl. the closing bit.
//  FSM states SYNC, LEFT, RIGHT:
//   SYNC : ignore data; on ws edge 1->0 (right closes) -> LEFT. Partial slots discarded.
//   LEFT : on close of left slot: cnt < MIN_BITS -> frame_err pulse, -> SYNC, locked=0;
//          else hold word in left_hold -> RIGHT.
//   RIGHT: on close of right slot: cnt < MIN_BITS -> frame_err, -> SYNC, locked=0;
//          else left_chan<=left_hold, right_chan<=word, sample_valid pulse, locked=1 -> LEFT.
//  Latency: sample_valid asserts 1 clk after the bit tick that closes the right slot.
//  Outputs hold between pulses; sample_valid and frame_err never assert in the same clk.
//  No sclk activity: state holds indefinitely; no timeout.
//  lrclk glitch mid-slot = early close -> handled as short slot if < MIN_BITS.
// STRUCTURE
//  Shared package audio_pkg: localparam I2S_W=16, typedef logic signed [15:0] sample_t,
//   enum {SYNC, LEFT, RIGHT} i2s_rx_state_t.
//  One sub-module: sync2 (2-flop synchroniser, async active-low reset), instanced x3.
//  Slot shifter, counter, FSM and output regs live in i2s_rx itself.
// TESTING
//  1. reset_n low, toggle inputs -> all outputs 0, locked=0; release -> no pulse until a full L+R pair.
//  2. 32 sclk/frame, L=16'h8001, R=16'h7FFE -> after 1st full pair: sample_valid once,
//     left_chan=8001, right_chan=7FFE, locked=1; repeat 4 frames -> exactly 4 pulses.
//  3. 64 sclk/frame (32-bit slots), L=32'h1234ABCD -> left_chan=16'h1234 (extra bits dropped).
//  4. 24 sclk/frame (12-bit slots), L=12'hABC -> left_chan=16'hABC0 (LSB zero pad).
//  5. lrclk toggled after 5 bits of a right slot -> frame_err 1 pulse, locked=0, no
//     sample_valid; next clean frame -> relock, correct values.
//  6. reset_n asserted mid-right-slot -> outputs 0 same clk; after release first pair
//     discarded until a 1->0 lrclk edge, then correct data; sclk = clk/4 still decodes.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types: sample width, signed sample type and I2S receiver states.
package audio_pkg;
  localparam int I2S_W = 16;
  typedef logic signed [I2S_W-1:0] sample_t;
  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_rx_state_t;
endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sclk/lrclk/sdata and emits left/right sample pairs
// in the clk domain, with short-slot framing detection and lock indication.
module i2s_rx import audio_pkg::*; #(
  parameter int DATA_W   = I2S_W,
  parameter int MIN_BITS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              lrclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] left_chan,
  output logic [DATA_W-1:0] right_chan,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              locked
);
  localparam logic [5:0] DW6 = 6'(DATA_W);
  localparam logic [5:0] MB6 = 6'(MIN_BITS);

  logic [2:0] pin_a, pin_s;
  logic       sclk_s, ws_s, sd_s;
  logic       sclk_d, ws_prev;
  logic       tick, ws_edge;

  assign pin_a = {sclk, lrclk, sdata};
  for (genvar i = 0; i < 3; i++) begin : g_sync
    sync2 u_sync (.clk(clk), .rst_n(reset_n), .d(pin_a[i]), .q(pin_s[i]));
  end
  assign {sclk_s, ws_s, sd_s} = pin_s;

  assign tick    = sclk_s & ~sclk_d;
  assign ws_edge = tick & (ws_s != ws_prev);

  // Slot shifter: holds up to DATA_W bits right-aligned; cnt keeps counting past it.
  logic [DATA_W-1:0] shreg, shreg_app, word;
  logic [5:0]        cnt, cnt_app;

  always_comb begin
    shreg_app = (cnt < DW6) ? {shreg[DATA_W-2:0], sd_s} : shreg;
    cnt_app   = (cnt == 6'd63) ? cnt : cnt + 6'd1;
    word      = (cnt_app >= DW6) ? shreg_app : shreg_app << (DW6 - cnt_app);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d  <= 1'b0;
      ws_prev <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
    end else begin
      sclk_d <= sclk_s;
      if (tick) begin
        ws_prev <= ws_s;
        if (ws_edge) begin
          shreg <= '0;
          cnt   <= '0;
        end else begin
          if (cnt < DW6)     shreg <= {shreg[DATA_W-2:0], sd_s};
          if (cnt != 6'd63)  cnt   <= cnt + 6'd1;
        end
      end
    end
  end

  i2s_rx_state_t state, state_nxt;
  logic          do_hold, do_valid, do_err;
  logic          short_slot;

  assign short_slot = (cnt_app < MB6);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_nxt;
  end

  // Every ws edge closes the slot of the previous ws level.
  always_comb begin
    state_nxt = state;
    do_hold   = 1'b0;
    do_valid  = 1'b0;
    do_err    = 1'b0;
    if (ws_edge) begin
      case (state)
        SYNC:  if (!ws_s) state_nxt = LEFT;
        LEFT: begin
          if (short_slot) begin
            do_err    = 1'b1;
            state_nxt = SYNC;
          end else begin
            do_hold   = 1'b1;
            state_nxt = RIGHT;
          end
        end
        RIGHT: begin
          if (short_slot) begin
            do_err    = 1'b1;
            state_nxt = SYNC;
          end else begin
            do_valid  = 1'b1;
            state_nxt = LEFT;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  logic [DATA_W-1:0] left_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_hold    <= '0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= do_valid;
      frame_err    <= do_err;
      if (do_hold) left_hold <= word;
      if (do_valid) begin
        left_chan  <= left_hold;
        right_chan <= word;
        locked     <= 1'b1;
      end
      if (do_err) locked <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: serial I2S frames in, expected pairs queued and matched.
module tb_i2s_rx;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        sclk, lrclk, sdata;
  logic [15:0] left_chan, right_chan;
  logic        sample_valid, frame_err, locked;

  int n_chk = 0, n_fail = 0;
  int n_valid = 0, n_err = 0;
  int half = 4;
  logic last_lsb = 1'b0;
  logic [31:0] sb[$];

  i2s_rx dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
    .left_chan(left_chan), .right_chan(right_chan),
    .sample_valid(sample_valid), .frame_err(frame_err), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] align(input logic [63:0] v, input int n);
    logic [63:0] t;
    if (n >= 16) t = v >> (n - 16);
    else         t = v << (16 - n);
    return t[15:0];
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid || frame_err) check("excl", {31'd0, sample_valid & frame_err}, 32'd0);
      if (sample_valid) begin
        n_valid++;
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          logic [31:0] e;
          e = sb.pop_front();
          check("left", {16'd0, left_chan}, {16'd0, e[31:16]});
          check("right", {16'd0, right_chan}, {16'd0, e[15:0]});
        end
      end
      if (frame_err) n_err++;
    end
  end

  task automatic drive_bit(input logic ws, input logic sd);
    @(posedge clk); #1;
    sclk = 1'b0; lrclk = ws; sdata = sd;
    repeat (half) @(posedge clk);
    #1 sclk = 1'b1;
    repeat (half - 1) @(posedge clk);
  endtask

  // First tick of a slot carries the previous slot's LSB (one-bit delay).
  task automatic send_slot(input logic ch, input int n, input logic [63:0] val);
    for (int i = 0; i < n; i++)
      drive_bit(ch, (i == 0) ? last_lsb : val[n - i]);
    last_lsb = val[0];
  endtask

  task automatic send_frame(input int n, input logic [63:0] l, input logic [63:0] r, input bit exp);
    if (exp) sb.push_back({align(l, n), align(r, n)});
    send_slot(1'b0, n, l);
    send_slot(1'b1, n, r);
  endtask

  initial begin
    int v0, e0;
    reset_n = 1'b0; sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      sclk = i[0]; lrclk = i[1]; sdata = i[2];
    end
    @(negedge clk);
    check("rst_left", {16'd0, left_chan}, 32'd0);
    check("rst_right", {16'd0, right_chan}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    // Junk right slot, then four 16-bit frames.
    send_slot(1'b1, 16, 64'h5A5A);
    v0 = n_valid;
    send_frame(16, 64'h8001, 64'h7FFE, 1'b1);
    check("no_early", n_valid, 32'd0);
    for (int i = 0; i < 3; i++) send_frame(16, 64'h8001, 64'h7FFE, 1'b1);

    // 32-bit slots: extra LSBs dropped.
    sb.push_back({align(64'h1234ABCD, 32), align(64'hFEDC9876, 32)});
    send_slot(1'b0, 32, 64'h1234ABCD);
    check("pulses4", n_valid - v0, 32'd4);
    check("locked", {31'd0, locked}, 32'd1);
    send_slot(1'b1, 32, 64'hFEDC9876);

    // 12-bit slots: LSB zero padding.
    send_frame(12, 64'hABC, 64'h123, 1'b1);
    send_frame(12, 64'h5A5, 64'hFFF, 1'b1);

    // lrclk glitch after 5 bits of the right slot.
    send_slot(1'b0, 16, 64'hC3C3);
    v0 = n_valid; e0 = n_err;
    send_slot(1'b1, 5, 64'h15);
    send_slot(1'b0, 16, 64'h1111);
    check("glitch_err", n_err - e0, 32'd1);
    check("glitch_unlock", {31'd0, locked}, 32'd0);
    send_slot(1'b1, 16, 64'h2222);
    check("glitch_novalid", n_valid - v0, 32'd0);
    send_frame(16, 64'h1357, 64'h2468, 1'b1);
    send_slot(1'b0, 16, 64'h9999);
    check("relock", {31'd0, locked}, 32'd1);
    check("relock_pulse", n_valid - v0, 32'd1);

    // Reset in the middle of a right slot.
    for (int i = 0; i < 6; i++) drive_bit(1'b1, i[0]);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    check("mid_rst_left", {16'd0, left_chan}, 32'd0);
    check("mid_rst_right", {16'd0, right_chan}, 32'd0);
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) drive_bit(1'b1, i[1]);
    last_lsb = 1'b1;
    half = 2;
    v0 = n_valid;
    send_frame(16, 64'h4321, 64'hBCDE, 1'b1);
    send_frame(16, 64'h0F0F, 64'hF0F0, 1'b1);
    send_slot(1'b0, 16, 64'h0);
    repeat (20) @(posedge clk);
    check("fast_pulses", n_valid - v0, 32'd2);
    check("sb_drained", sb.size(), 32'd0);
    check("err_total", n_err, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
